tx_fifo_arbiter: RTL and testbench

Shares the 128-bit write port of the TX FIFO (128-bit write / 8-bit read, 4096-byte capacity) between NUM_REQ burst requesters. It reserves FIFO space per burst by tracking free bytes from the write and read sides. A burst is granted only when its full length fits, so FIFO overflow cannot occur in normal operation. The block sits between the bus-side producers (CPU path, DMA) and the TX FIFO write port; the byte-wide read side stays with the serializer.

---
 rtl/tx_fifo_arbiter_pkg.sv | 19 +
 rtl/tx_fifo_arbiter_if.sv | 37 +++
 rtl/tx_fifo_arbiter_rr_pick.sv | 31 +++
 rtl/tx_fifo_arbiter.sv | 164 ++++++++++++++++
 tb/tb_tx_fifo_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_fifo_arbiter_pkg.sv
// Shared types and sizing helpers for the TX FIFO write-port arbiter.
package tx_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int FIFO_BYTES_DEF = 4096;
  localparam int DATA_W_DEF     = 128;
  localparam int RD_W_DEF       = 8;
  localparam int BYTES_PER_WORD = DATA_W_DEF / RD_W_DEF;

  // free_bytes must hold the full capacity value, hence the extra bit.
  function automatic int fb_width(input int fifo_bytes);
    return $clog2(fifo_bytes) + 1;
  endfunction

endpackage

// File: rtl/tx_fifo_arbiter_if.sv
// Requester, TX FIFO and status signals of the arbiter bundled as one interface.
interface tx_fifo_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 128,
  parameter int LEN_W   = 4,
  parameter int FB_W    = tx_fifo_arb_pkg::fb_width(tx_fifo_arb_pkg::FIFO_BYTES_DEF)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*LEN_W-1:0]  req_len_m1;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ*DATA_W-1:0] src_data;
  logic [NUM_REQ-1:0]        src_valid;
  logic [NUM_REQ-1:0]        src_ready;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      fifo_wr_en;
  logic                      fifo_wr_full;
  logic                      fifo_rd_en;
  logic                      fifo_rd_empty;
  logic [FB_W-1:0]           free_bytes;
  logic                      busy;
  logic                      ovf_err;

  // master: producers plus FIFO side; slave: the arbiter itself
  modport master (
    output req_valid, req_len_m1, src_data, src_valid,
           fifo_wr_full, fifo_rd_en, fifo_rd_empty,
    input  gnt, src_ready, fifo_wr_data, fifo_wr_en,
           free_bytes, busy, ovf_err
  );

  modport slave (
    input  req_valid, req_len_m1, src_data, src_valid,
           fifo_wr_full, fifo_rd_en, fifo_rd_empty,
    output gnt, src_ready, fifo_wr_data, fifo_wr_en,
           free_bytes, busy, ovf_err
  );
endinterface

// File: rtl/tx_fifo_arbiter_rr_pick.sv
// One-hot winner selection: round-robin after last_gnt, or fixed lowest-index
// priority when prio_en is set.
module tx_arb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_gnt,
  input  logic               prio_en,
  output logic [NUM_REQ-1:0] win
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (prio_en)
        idx = IDX_W'(k);
      else
        idx = IDX_W'((int'(last_gnt) + 1 + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// Shares the TX FIFO write port between burst requesters, reserving space per burst.
// Define TX_ARB_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
//   state | meaning
//   IDLE  | choose/lock a winner, grant once its whole burst fits in free_bytes
//   BURST | stream words from the granted requester until its count runs out
module tx_fifo_arbiter
  import tx_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_W       = RD_W_DEF,
  parameter int FIFO_BYTES = FIFO_BYTES_DEF,
  parameter int LEN_W      = 4
) (
  input logic               clk,
  input logic               rst,
  tx_fifo_arbiter_if.slave  bus
);

  localparam int BPW    = DATA_W / RD_W;
  localparam int FB_W   = fb_width(FIFO_BYTES);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int RES_W  = LEN_W + 1 + $clog2(BPW);
  localparam int CALC_W = ((RES_W > FB_W) ? RES_W : FB_W) + 2;

`ifdef TX_ARB_PRIORITY_EN
  localparam logic PRIO_MODE = 1'b1;
`else
  localparam logic PRIO_MODE = 1'b0;
`endif

  arb_state_t         state;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   last_gnt;
  logic [IDX_W-1:0]   lock_idx;
  logic               lock_valid;
  logic [LEN_W-1:0]   words_left;
  logic [NUM_REQ-1:0] gnt_q;
  logic               busy_q;
  logic               ovf_q;
  logic [FB_W-1:0]    free_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   cand_idx;
  logic               cand_valid;
  logic [LEN_W-1:0]   cand_len;
  logic [CALC_W-1:0]  cand_bytes;
  logic               cand_fits;
  logic               grant;
  logic               rd_inc;
  logic               wr_accept;
  logic [NUM_REQ-1:0] src_ready_c;
  logic [CALC_W-1:0]  free_ext;
  logic [FB_W-1:0]    free_next;

  tx_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid (bus.req_valid),
    .last_gnt  (last_gnt),
    .prio_en   (PRIO_MODE),
    .win       (pick_onehot)
  );

  always_comb begin
    pick_idx   = '0;
    pick_valid = |pick_onehot;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
  end

  // A locked winner keeps the slot while its request stays up, so a large
  // burst waiting for space is never overtaken by smaller ones.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    if (lock_valid && bus.req_valid[lock_idx]) begin
      cand_valid = 1'b1;
      cand_idx   = lock_idx;
    end else if (pick_valid) begin
      cand_valid = 1'b1;
      cand_idx   = pick_idx;
    end
    cand_len   = bus.req_len_m1[int'(cand_idx)*LEN_W +: LEN_W];
    cand_bytes = (CALC_W'(cand_len) + CALC_W'(1)) * CALC_W'(BPW);
    cand_fits  = cand_bytes <= CALC_W'(free_q);
    grant      = (state == IDLE) && cand_valid && cand_fits;
  end

  always_comb begin
    src_ready_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_ready_c[i] = (state == BURST) && (gnt_idx == IDX_W'(i)) && !bus.fifo_wr_full;
    end
    wr_accept = bus.src_valid[gnt_idx] & src_ready_c[gnt_idx];
  end

  always_comb begin
    rd_inc   = bus.fifo_rd_en & ~bus.fifo_rd_empty;
    free_ext = CALC_W'(free_q) + CALC_W'(rd_inc);
    if (grant) free_ext = free_ext - cand_bytes;
    free_next = (free_ext > CALC_W'(FIFO_BYTES)) ? FB_W'(FIFO_BYTES) : free_ext[FB_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt_q      <= '0;
      gnt_idx    <= '0;
      last_gnt   <= IDX_W'(NUM_REQ - 1);
      lock_idx   <= '0;
      lock_valid <= 1'b0;
      words_left <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      free_q     <= FB_W'(FIFO_BYTES);
    end else begin
      gnt_q  <= '0;
      free_q <= free_next;
      if (state == BURST && bus.fifo_wr_full) ovf_q <= 1'b1;
      case (state)
        IDLE: begin
          if (lock_valid && !bus.req_valid[lock_idx]) lock_valid <= 1'b0;
          if (grant) begin
            gnt_q      <= NUM_REQ'(1) << cand_idx;
            gnt_idx    <= cand_idx;
            last_gnt   <= cand_idx;
            words_left <= cand_len;
            lock_valid <= 1'b0;
            busy_q     <= 1'b1;
            state      <= BURST;
          end else if (cand_valid) begin
            lock_valid <= 1'b1;
            lock_idx   <= cand_idx;
          end
        end
        BURST: begin
          if (wr_accept) begin
            if (words_left == '0) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              words_left <= words_left - LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.src_ready    = src_ready_c;
  assign bus.fifo_wr_en   = wr_accept;
  assign bus.fifo_wr_data = bus.src_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign bus.free_bytes   = free_q;
  assign bus.busy         = busy_q;
  assign bus.ovf_err      = ovf_q;

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Directed bench for tx_fifo_arbiter: grant timing, arbitration, space reservation,
// reset mid-burst and overflow protection.
module tb_tx_fifo_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 128;
  localparam int LEN_W   = 4;
  localparam int FB_W    = 13;

`ifdef TX_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic tb_rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  tx_fifo_arbiter_if #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .FB_W    (FB_W)
  ) bus ();

  tx_fifo_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .RD_W       (8),
    .FIFO_BYTES (4096),
    .LEN_W      (LEN_W)
  ) dut (
    .clk (clk),
    .rst (tb_rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_len(input int i, input int len);
    bus.req_len_m1[i*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic set_data(input int i, input logic [127:0] d);
    bus.src_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Request, expect the grant one edge later, then stream len+1 words.
  task automatic run_burst(input int idx, input int len, input logic [127:0] d);
    bus.req_valid[idx] = 1'b1;
    set_len(idx, len);
    tick();
    chk("burst_gnt", bus.gnt, 128'(1) << idx);
    bus.req_valid[idx] = 1'b0;
    bus.src_valid[idx] = 1'b1;
    set_data(idx, d);
    repeat (len + 1) tick();
    bus.src_valid[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [127:0] exp_g;

    tb_rst             = 1'b1;
    bus.req_valid      = '0;
    bus.req_len_m1     = '0;
    bus.src_data       = '0;
    bus.src_valid      = '0;
    bus.fifo_wr_full   = 1'b0;
    bus.fifo_rd_en     = 1'b0;
    bus.fifo_rd_empty  = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_gnt",       bus.gnt,        0);
    chk("rst_src_ready", bus.src_ready,  0);
    chk("rst_wr_en",     bus.fifo_wr_en, 0);
    chk("rst_busy",      bus.busy,       0);
    chk("rst_ovf",       bus.ovf_err,    0);
    chk("rst_free",      bus.free_bytes, 4096);
    tb_rst = 1'b0;
    tick();

    // single burst of 4 words from requester 0
    bus.req_valid = 2'b01;
    set_len(0, 3);
    tick();
    chk("sb_gnt",       bus.gnt,        1);
    chk("sb_src_ready", bus.src_ready,  1);
    chk("sb_busy",      bus.busy,       1);
    chk("sb_free",      bus.free_bytes, 4032);
    bus.req_valid = 2'b00;
    bus.src_valid = 2'b01;
    set_data(0, 128'hA);
    #1;
    chk("sb_wr_en",   bus.fifo_wr_en,   1);
    chk("sb_wr_data", bus.fifo_wr_data, 128'hA);
    for (int w = 1; w < 4; w++) begin
      tick();
      chk("sb_gnt_pulse", bus.gnt, 0);
      set_data(0, 128'hA + 128'(w));
      #1;
      chk("sb_wr_en",   bus.fifo_wr_en,   1);
      chk("sb_wr_data", bus.fifo_wr_data, 128'hA + 128'(w));
    end
    tick();
    chk("sb_done_busy",  bus.busy,      0);
    chk("sb_done_ready", bus.src_ready, 0);
    bus.src_valid = 2'b00;
    #1;
    chk("sb_done_wr_en", bus.fifo_wr_en, 0);

    // contention: both requesters held, single-word bursts
    bus.req_valid = 2'b11;
    set_len(0, 0);
    set_len(1, 0);
    set_data(0, 128'h100);
    set_data(1, 128'h200);
    bus.src_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k % 2 == 1)        exp_g = 0;
      else if (PRIO)         exp_g = 1;
      else if ((k / 2) % 2 == 0) exp_g = 2;
      else                   exp_g = 1;
      chk("ct_gnt", bus.gnt, exp_g);
      if (k % 2 == 0) begin
        #1;
        chk("ct_wr_data", bus.fifo_wr_data, (exp_g == 1) ? 128'h100 : 128'h200);
      end
    end
    bus.req_valid = 2'b00;
    bus.src_valid = 2'b00;
    tick();
    chk("ct_withdraw_gnt", bus.gnt,        0);
    chk("ct_busy",         bus.busy,       0);
    chk("ct_free",         bus.free_bytes, 3968);

    // reset after 5 of 16 words
    bus.req_valid = 2'b01;
    set_len(0, 15);
    tick();
    chk("rm_gnt", bus.gnt, 1);
    bus.req_valid = 2'b00;
    bus.src_valid = 2'b01;
    set_data(0, 128'h50);
    repeat (5) tick();
    #1;
    chk("rm_wr_en_before", bus.fifo_wr_en, 1);
    tb_rst = 1'b1;
    #1;
    chk("rm_wr_en",     bus.fifo_wr_en, 0);
    chk("rm_src_ready", bus.src_ready,  0);
    chk("rm_free",      bus.free_bytes, 4096);
    tick();
    tb_rst        = 1'b0;
    bus.src_valid = 2'b00;
    tick();
    chk("rm_post_busy", bus.busy,       0);
    chk("rm_post_gnt",  bus.gnt,        0);
    chk("rm_post_free", bus.free_bytes, 4096);

    // reservation and read in the same edge
    bus.req_valid     = 2'b01;
    set_len(0, 15);
    bus.fifo_rd_en    = 1'b1;
    bus.fifo_rd_empty = 1'b0;
    tick();
    chk("sr_gnt",  bus.gnt,        1);
    chk("sr_free", bus.free_bytes, 3841);
    bus.fifo_rd_en    = 1'b0;
    bus.fifo_rd_empty = 1'b1;
    bus.req_valid     = 2'b00;
    bus.src_valid     = 2'b01;
    repeat (16) tick();
    bus.src_valid = 2'b00;
    chk("sr_busy",      bus.busy,       0);
    chk("sr_free_hold", bus.free_bytes, 3841);

    // read while empty is ignored, then bring free space down to 8
    bus.fifo_rd_en    = 1'b1;
    bus.fifo_rd_empty = 1'b1;
    tick();
    chk("sw_empty_read", bus.free_bytes, 3841);
    bus.fifo_rd_empty = 1'b0;
    repeat (7) tick();
    bus.fifo_rd_en    = 1'b0;
    bus.fifo_rd_empty = 1'b1;
    chk("sw_reads", bus.free_bytes, 3848);
    for (int b = 0; b < 15; b++) run_burst(0, 15, 128'h1000 + 128'(b));
    chk("sw_free8", bus.free_bytes, 8);

    // 16-byte request waits for space
    bus.req_valid = 2'b10;
    set_len(1, 0);
    repeat (3) begin
      tick();
      chk("sw_wait_gnt", bus.gnt, 0);
    end
    chk("sw_wait_busy", bus.busy, 0);
    bus.fifo_rd_en    = 1'b1;
    bus.fifo_rd_empty = 1'b0;
    for (int r = 0; r < 8; r++) begin
      tick();
      chk("sw_read_gnt", bus.gnt, 0);
    end
    bus.fifo_rd_en    = 1'b0;
    bus.fifo_rd_empty = 1'b1;
    chk("sw_free16", bus.free_bytes, 16);
    tick();
    chk("sw_gnt1",   bus.gnt,        2'b10);
    chk("sw_free0",  bus.free_bytes, 0);
    bus.req_valid = 2'b00;
    bus.src_valid = 2'b10;
    set_data(1, 128'h77);
    #1;
    chk("sw_wr_en",   bus.fifo_wr_en,   1);
    chk("sw_wr_data", bus.fifo_wr_data, 128'h77);
    tick();
    bus.src_valid = 2'b00;
    chk("sw_busy_done", bus.busy, 0);

    // FIFO reports full during a burst
    tb_rst = 1'b1;
    tick();
    tb_rst = 1'b0;
    tick();
    bus.req_valid = 2'b01;
    set_len(0, 1);
    tick();
    chk("ff_gnt", bus.gnt, 1);
    bus.req_valid    = 2'b00;
    bus.fifo_wr_full = 1'b1;
    bus.src_valid    = 2'b01;
    set_data(0, 128'hF0);
    #1;
    chk("ff_src_ready", bus.src_ready,  0);
    chk("ff_wr_en",     bus.fifo_wr_en, 0);
    tick();
    chk("ff_ovf",  bus.ovf_err, 1);
    chk("ff_busy", bus.busy,    1);
    bus.fifo_wr_full = 1'b0;
    #1;
    chk("ff_ready_back", bus.src_ready, 1);
    chk("ff_ovf_sticky", bus.ovf_err,   1);
    tick();
    tick();
    bus.src_valid = 2'b00;
    chk("ff_busy_done", bus.busy,       0);
    chk("ff_ovf_idle",  bus.ovf_err,    1);
    chk("ff_free",      bus.free_bytes, 4064);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
